// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    CALC,
    FIM
  } estado_t;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/subtrator_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module subtrator_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor, LSB first, one reused full-subtractor cell and a borrow flop.
module subtrator_serial
  import sub_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(N - 1);

  estado_t          state_q;
  logic [N-1:0]     sh_a_q;
  logic [N-1:0]     sh_b_q;
  logic [N-1:0]     sh_d_q;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  // Operand signs are shifted out during CALC, so keep them for the overflow check.
  logic             sign_a_q;
  logic             sign_b_q;

  logic cell_d;
  logic cell_bo;

  subtrator_1bit u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign busy = (state_q == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OCIOSO;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_d_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (start) begin
            sh_a_q   <= a;
            sh_b_q   <= b;
            brw_q    <= bin;
            cnt_q    <= '0;
            sign_a_q <= a[N-1];
            sign_b_q <= b[N-1];
            state_q  <= CALC;
          end
        end
        CALC: begin
          sh_a_q <= {1'b0, sh_a_q[N-1:1]};
          sh_b_q <= {1'b0, sh_b_q[N-1:1]};
          sh_d_q <= {cell_d, sh_d_q[N-1:1]};
          brw_q  <= cell_bo;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LastBit) begin
            state_q <= FIM;
          end
        end
        FIM: begin
          diff     <= sh_d_q;
          bout     <= brw_q;
          overflow <= (sign_a_q != sign_b_q) && (sh_d_q[N-1] != sign_a_q);
          done     <= 1'b1;
          state_q  <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

endmodule
